// File: rtl/ram_arb_pkg.sv
// Shared types for ram_port_arbiter: request struct, FSM state and the
// round-robin pointer helper. Request fields are sized to generous maximums
// so one struct serves every legal parameterisation; the top slices it down.
package ram_arb_pkg;

  localparam int ARB_MAX_ADDR_W = 64;
  localparam int ARB_MAX_DATA_W = 256;
  localparam int ARB_MAX_STRB_W = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                      we;
    logic                      lock;
    logic [ARB_MAX_ADDR_W-1:0] addr;
    logic [ARB_MAX_DATA_W-1:0] wdata;
    logic [ARB_MAX_STRB_W-1:0] wstrb;
  } arb_req_t;

  // Next search start after a grant to idx: one past the winner, wrapping at n
  function automatic int rr_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker: one-hot grant of the first set request found
// searching upward from ptr_i with wrap-around. Purely combinational.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_any_o
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins last
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = IW'((int'(ptr_i) + off) % N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        gnt_any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_REQ requesters,
// with burst locking and a one-cycle response pulse to the winner.
// Optional feature: define RAM_ARB_STATS_EN to add per-requester saturating
// accept counters on grant_cnt_o.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 32,
  parameter  int BYTE_WIDTH = 8,
  localparam int STRB_W     = DATA_WIDTH / BYTE_WIDTH,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic [N_REQ-1:0]                  req_we_i,
  input  logic [N_REQ-1:0]                  req_lock_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [N_REQ-1:0][STRB_W-1:0]      req_wstrb_i,
  output logic [N_REQ-1:0]                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic [DATA_WIDTH-1:0]             ram_wdata_o,
  output logic [STRB_W-1:0]                 ram_byte_en_o,
  output logic                              ram_write_en_o,
  input  logic [DATA_WIDTH-1:0]             ram_rdata_i
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0]            grant_cnt_o
`endif
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  arb_req_t         sel_req;
  logic             unused_sel;

  // Who may compete: everyone when idle, only the owner while locked, nobody in reset
  always_comb begin
    elig = req_valid_i;
    if (state_q == ST_LOCKED) elig = req_valid_i & (N_REQ'(1) << owner_q);
    if (rst_i) elig = '0;
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i    (elig),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_any_o(gnt_any)
  );

  assign req_ready_o = gnt;

  // Gather the winner's request into one struct
  always_comb begin
    sel_req       = '0;
    sel_req.we    = req_we_i[gnt_idx];
    sel_req.lock  = req_lock_i[gnt_idx];
    sel_req.addr  = ARB_MAX_ADDR_W'(req_addr_i[gnt_idx]);
    sel_req.wdata = ARB_MAX_DATA_W'(req_wdata_i[gnt_idx]);
    sel_req.wstrb = ARB_MAX_STRB_W'(req_wstrb_i[gnt_idx]);
  end

  // Upper struct bits beyond the configured widths are always zero
  assign unused_sel = ^{sel_req.addr, sel_req.wdata, sel_req.wstrb};

  // RAM port: enables only on an accepted write; a zero-strobe write is a no-op
  always_comb begin
    ram_addr_o     = sel_req.addr[ADDR_WIDTH-1:0];
    ram_wdata_o    = sel_req.wdata[DATA_WIDTH-1:0];
    ram_byte_en_o  = '0;
    ram_write_en_o = 1'b0;
    if (gnt_any && sel_req.we) begin
      ram_byte_en_o  = sel_req.wstrb[STRB_W-1:0];
      ram_write_en_o = |sel_req.wstrb[STRB_W-1:0];
    end
  end

  // Next state: advance pointer past the winner, enter/leave LOCKED per lock bit
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = gnt;
    if (gnt_any) begin
      rr_ptr_d = IDX_W'(rr_next(int'(gnt_idx), N_REQ));
      owner_d  = gnt_idx;
      state_d  = sel_req.lock ? ST_LOCKED : ST_IDLE;
    end
  end

  // Lock FSM, pointer and response pulse; reset drops any pending response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = ram_rdata_i;

`ifdef RAM_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] cnt_q, cnt_d;

  // Per-requester accept counts, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter (N_REQ=4, 16-bit addr, 32-bit data).
// Responses are predicted into a scoreboard queue when stimulus is driven and
// matched by a monitor on the falling edge. Stats check runs when
// RAM_ARB_STATS_EN is defined.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           req_valid_i;
  logic [N-1:0]           req_ready_o;
  logic [N-1:0]           req_we_i;
  logic [N-1:0]           req_lock_i;
  logic [N-1:0][AW-1:0]   req_addr_i;
  logic [N-1:0][DW-1:0]   req_wdata_i;
  logic [N-1:0][SW-1:0]   req_wstrb_i;
  logic [N-1:0]           rsp_valid_o;
  logic [DW-1:0]          rsp_rdata_o;
  logic [AW-1:0]          ram_addr_o;
  logic [DW-1:0]          ram_wdata_o;
  logic [SW-1:0]          ram_byte_en_o;
  logic                   ram_write_en_o;
  logic [DW-1:0]          ram_rdata_i;
`ifdef RAM_ARB_STATS_EN
  logic [N-1:0][31:0]     grant_cnt_o;
`endif

  ram_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_lock_i    (req_lock_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_wstrb_i   (req_wstrb_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_byte_en_o (ram_byte_en_o),
    .ram_write_en_o(ram_write_en_o),
    .ram_rdata_i   (ram_rdata_i)
`ifdef RAM_ARB_STATS_EN
    ,
    .grant_cnt_o   (grant_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: byte-enabled write, read data one cycle after address
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_write_en_o) begin
      for (int b = 0; b < SW; b++)
        if (ram_byte_en_o[b]) mem[ram_addr_o[7:0]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
    end
    ram_rdata_i <= mem[ram_addr_o[7:0]];
  end

  typedef struct {
    int           cyc;
    logic [N-1:0] mask;
    bit           cd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid_o != '0) begin
        if (exp_q.size() == 0) chk("unexp_rsp", 64'(rsp_valid_o), 64'h0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rsp_mask", 64'(rsp_valid_o), 64'(mon_e.mask));
          chk("rsp_cyc", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.cd) chk("rsp_data", 64'(rsp_rdata_o), 64'(mon_e.data));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("rsp_miss", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input bit lk);
    req_we_i[i]    = we;
    req_addr_i[i]  = a;
    req_wdata_i[i] = d;
    req_wstrb_i[i] = s;
    req_lock_i[i]  = lk;
  endtask

  // One cycle: drive valids, check grant and RAM port, predict the response
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] g,
                      input bit cd, input logic [DW-1:0] rd);
    int   w;
    exp_t e;
    @(negedge clk);
    req_valid_i = v;
    #1;
    chk("ready", 64'(req_ready_o), 64'(g));
    w = -1;
    for (int i = 0; i < N; i++) if (g[i]) w = i;
    if (w >= 0) begin
      chk("ram_addr", 64'(ram_addr_o), 64'(req_addr_i[w]));
      chk("ram_be", 64'(ram_byte_en_o), req_we_i[w] ? 64'(req_wstrb_i[w]) : 64'h0);
      chk("ram_we", 64'(ram_write_en_o), 64'(req_we_i[w] && (req_wstrb_i[w] != '0)));
      if (req_we_i[w] && (req_wstrb_i[w] != '0)) chk("ram_wdata", 64'(ram_wdata_o), 64'(req_wdata_i[w]));
      e.cyc = cyc + 1; e.mask = g; e.cd = cd; e.data = rd;
      exp_q.push_back(e);
    end else begin
      chk("ram_be_idle", 64'(ram_byte_en_o), 64'h0);
      chk("ram_we_idle", 64'(ram_write_en_o), 64'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid_i = '1;
    req_we_i    = '1;
    req_wstrb_i = '1;
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'h0);
    chk("rst_be", 64'(ram_byte_en_o), 64'h0);
    chk("rst_we", 64'(ram_write_en_o), 64'h0);
    chk("rst_rsp", 64'(rsp_valid_o), 64'h0);
    repeat (2) @(negedge clk);
    req_valid_i = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(16'h20 + i), '0, '1, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    req_valid_i = '0; req_we_i = '0; req_lock_i = '0;
    req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
    do_reset();

    // Round robin with all four reading
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'hF, 4'h2, 1'b0, '0);
    step(4'hF, 4'h4, 1'b0, '0);
    step(4'hF, 4'h8, 1'b0, '0);
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'h0, 4'h0, 1'b0, '0);

    // Full write then read-back by another requester
    set_req(2, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
    step(4'h4, 4'h4, 1'b0, '0);
    set_req(1, 1'b0, 16'h0010, '0, 4'h0, 1'b0);
    step(4'h2, 4'h2, 1'b1, 32'hDEADBEEF);

    // Partial write, then read back (same requester back-to-back)
    set_req(1, 1'b1, 16'h0010, 32'h0000AAAA, 4'h3, 1'b0);
    step(4'h2, 4'h2, 1'b0, '0);
    set_req(1, 1'b0, 16'h0010, '0, 4'h0, 1'b0);
    step(4'h2, 4'h2, 1'b1, 32'hDEADAAAA);

    // Zero-strobe write is a no-op that still responds
    set_req(3, 1'b1, 16'h0010, 32'h12345678, 4'h0, 1'b0);
    step(4'h8, 4'h8, 1'b0, '0);
    set_req(3, 1'b0, 16'h0010, '0, 4'h0, 1'b0);
    step(4'h8, 4'h8, 1'b1, 32'hDEADAAAA);
    step(4'h0, 4'h0, 1'b0, '0);

    // Locked burst: 3 locked beats plus the unlocking beat, then req 1
    do_reset();
    set_req(0, 1'b0, 16'h0020, '0, 4'h0, 1'b1);
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'hF, 4'h1, 1'b0, '0);
    set_req(0, 1'b0, 16'h0020, '0, 4'h0, 1'b0);
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'hF, 4'h2, 1'b0, '0);

    // Locked owner idle: nobody else gets in
    set_req(0, 1'b0, 16'h0020, '0, 4'h0, 1'b1);
    step(4'h1, 4'h1, 1'b0, '0);
    step(4'hE, 4'h0, 1'b0, '0);
    step(4'hE, 4'h0, 1'b0, '0);
    set_req(0, 1'b0, 16'h0020, '0, 4'h0, 1'b0);
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'hF, 4'h2, 1'b0, '0);
    step(4'h0, 4'h0, 1'b0, '0);

    // Reset right after a read accept drops its response; pointer restarts at 0
    set_req(2, 1'b0, 16'h0010, '0, 4'h0, 1'b0);
    @(negedge clk);
    req_valid_i = 4'h4;
    #1;
    chk("pre_rst_ready", 64'(req_ready_o), 64'h4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid_i = '0;
    #1;
    chk("rst_rsp_drop", 64'(rsp_valid_o), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(4'h0, 4'h0, 1'b0, '0);
    step(4'h0, 4'h0, 1'b0, '0);
    step(4'hF, 4'h1, 1'b0, '0);
    step(4'h0, 4'h0, 1'b0, '0);

`ifdef RAM_ARB_STATS_EN
    // Five accepts on requester 3 only
    do_reset();
    for (int k = 0; k < 5; k++) step(4'h8, 4'h8, 1'b0, '0);
    step(4'h0, 4'h0, 1'b0, '0);
    for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt_o[i]), (i == 3) ? 64'd5 : 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("q_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
